// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 message-schedule definitions: word width, round count,
// small sigma functions and the schedule-reader state encoding.
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA256_ROUNDS = 64;

  typedef logic [SHA256_WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sha256_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sha256_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// -----------------------------------------------------------------------------
// sha256_w_next
// Combinational next schedule word for a 16-word sliding window whose
// element k holds W_{t+k}:
//   W_{t+16} = sigma1(W_{t+14}) + W_{t+9} + sigma0(W_{t+1}) + W_t  (mod 2^32)
// Ports:
//   w0, w1, w9, w14 : window taps W_t, W_{t+1}, W_{t+9}, W_{t+14}
//   w_next          : W_{t+16}
// Also usable by the pipelined schedule stages.
// -----------------------------------------------------------------------------
module sha256_w_next
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_next
);

  assign w_next = sha256_sigma1(w14) + w9 + sha256_sigma0(w1) + w0;

endmodule

// File: rtl/sha256_w_stream.sv
// -----------------------------------------------------------------------------
// sha256_w_stream
// Iterative SHA-256 message-schedule reader. Accepts one padded 512-bit
// block and streams W0..W(ROUNDS-1), one word per handshake, expanding the
// schedule on the fly in a 16-word sliding window.
//
// Ports:
//   CLK       : clock, rising edge
//   RST       : asynchronous active-low reset
//   in_valid  : block offered on block_in
//   in_ready  : block accepted when in_valid && in_ready at a clock edge
//   block_in  : padded block, W0 at [511:480] ... W15 at [31:0]
//   w_valid   : w_out holds a valid schedule word
//   w_ready   : consumer accepts the current word
//   w_out     : current schedule word W_t
//   w_idx     : t
//   w_last    : w_valid && w_idx == ROUNDS-1
//   busy      : streaming a block
//
// Build option SHA256_WSTREAM_PREFETCH_EN: adds a one-block holding buffer so
// the next block can be accepted while streaming and started with no bubble.
// -----------------------------------------------------------------------------
module sha256_w_stream
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_e       state_q, state_d;
  word_t        win_q [16];
  logic [5:0]   idx_q;
  word_t        w_next;
  logic         in_hs, out_hs, last_hs;
  logic         load_win;
  logic [511:0] load_blk;

`ifdef SHA256_WSTREAM_PREFETCH_EN
  logic [511:0] buf_q;
  logic         full_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs and handshakes. in_ready depends on registered state only.
  // ---------------------------------------------------------------------------
  assign w_valid = (state_q == STREAM);
  assign busy    = (state_q == STREAM);
  assign w_out   = win_q[0];
  assign w_idx   = idx_q;
  assign w_last  = w_valid && (idx_q == LAST_IDX);

`ifdef SHA256_WSTREAM_PREFETCH_EN
  assign in_ready = !full_q;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = w_valid && w_ready;
  assign last_hs = out_hs && (idx_q == LAST_IDX);

  sha256_w_next u_w_next (
    .w0     (win_q[0]),
    .w1     (win_q[1]),
    .w9     (win_q[9]),
    .w14    (win_q[14]),
    .w_next (w_next)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and window-load decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    load_win = 1'b0;
    load_blk = block_in;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d  = STREAM;
          load_win = 1'b1;
        end
      end
      STREAM: begin
        if (last_hs) begin
`ifdef SHA256_WSTREAM_PREFETCH_EN
          // Chain straight into the next block when one is waiting, either
          // in the buffer or arriving on this very edge.
          if (full_q) begin
            load_win = 1'b1;
            load_blk = buf_q;
          end else if (in_hs) begin
            load_win = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sliding window and index counter
  // ---------------------------------------------------------------------------
  // NOTE: the window is reset as well, because w_out must read zero during
  // reset and a partial block must never leak into the next stream.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 16; k++) win_q[k] <= '0;
      idx_q <= '0;
    end else if (load_win) begin
      for (int k = 0; k < 16; k++) win_q[k] <= load_blk[511-32*k -: 32];
      idx_q <= '0;
    end else if (out_hs) begin
      // Words past t=47 are computed but never emitted; that is harmless.
      for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
      win_q[15] <= w_next;
      idx_q     <= idx_q + 6'd1;
    end
  end

`ifdef SHA256_WSTREAM_PREFETCH_EN
  // ---------------------------------------------------------------------------
  // Holding buffer: fills on an input handshake while streaming, frees when
  // its block moves into the window. A block arriving with the final output
  // handshake goes straight to the window instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else if ((state_q == STREAM) && in_hs && !last_hs) begin
      buf_q  <= block_in;
      full_q <= 1'b1;
    end else if (last_hs && full_q) begin
      full_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_w_stream.sv
// -----------------------------------------------------------------------------
// tb_sha256_w_stream
// Self-checking bench for sha256_w_stream. The reference schedule is built
// directly from the SHA-256 recurrence over a 64-entry array; inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sha256_w_stream;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] block_in = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  sha256_w_stream dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .block_in (block_in),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-word reference schedule for a block.
  task automatic build_ref(input logic [511:0] blk);
    logic [511:0] tmp;
    tmp = blk;
    for (int k = 0; k < 16; k++) begin
      exp_w[k] = tmp[511:480];
      tmp      = tmp << 32;
    end
    for (int t = 16; t < 64; t++)
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b = {b[479:0], 32'($urandom)};
    return b;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance,
  // where W0 must already be presented.
  task automatic load_block(input logic [511:0] blk);
    int n;
    build_ref(blk);
    in_valid = 1'b1;
    block_in = blk;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("load in_ready", in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Consumes 64 words from the current falling edge, checking every cycle
  // (including stalls) against exp_w. Returns at the falling edge after the
  // final handshake.
  task automatic run_stream(input bit rnd_ready, input string tag);
    int t, cyc, lasts;
    t = 0; cyc = 0; lasts = 0;
    while (t < 64) begin
      if (cyc > 2000) begin
        check({tag, " timeout"}, t, 64);
        break;
      end
      check({tag, " w_valid"}, w_valid, 1);
      check({tag, " busy"}, busy, 1);
      check({tag, " w_idx"}, w_idx, t);
      check({tag, " w_out"}, w_out, exp_w[t]);
      check({tag, " w_last"}, w_last, (t == 63));
`ifndef SHA256_WSTREAM_PREFETCH_EN
      check({tag, " in_ready"}, in_ready, 0);
`endif
      w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid && w_ready) begin
        got_w[t] = w_out;
        if (w_last) lasts++;
        t++;
      end
      cyc++;
      @(negedge CLK);
    end
    check({tag, " last count"}, lasts, 1);
  endtask

  initial begin
    logic [511:0] abc, blk_a, blk_b;
    int n;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst in_ready", in_ready, 1);
    check("rst w_valid", w_valid, 0);
    check("rst w_out", w_out, 0);
    check("rst w_idx", w_idx, 0);
    check("rst w_last", w_last, 0);
    check("rst busy", busy, 0);
    RST = 1'b1;
    @(negedge CLK);

    // "abc" padded block, consumer always ready
    abc = {32'h61626380, 448'h0, 32'h00000018};
    load_block(abc);
    run_stream(1'b0, "abc");
    check("abc W16", got_w[16], 32'h61626380);
    check("abc W17", got_w[17], 32'h000F0000);
    check("abc W18", got_w[18], 32'h7DA86405);
    w_ready = 1'b0;
    check("abc end w_valid", w_valid, 0);
    check("abc end in_ready", in_ready, 1);

    // Same block, random back-pressure
    load_block(abc);
    run_stream(1'b1, "abc_rnd");
    w_ready = 1'b0;

    // All-zero block, then back to IDLE
    load_block('0);
    run_stream(1'b0, "zero");
    w_ready = 1'b0;
    check("zero end w_valid", w_valid, 0);
    check("zero end busy", busy, 0);
    check("zero end in_ready", in_ready, 1);

    // Next block offered throughout a stream
    blk_a = rand_block();
    blk_b = rand_block();
    load_block(blk_a);
    in_valid = 1'b1;
    block_in = blk_b;
    run_stream(1'b0, "held_a");
`ifdef SHA256_WSTREAM_PREFETCH_EN
    // Zero bubble: block B index 0 directly follows block A index 63.
    in_valid = 1'b0;
    check("chain w_valid", w_valid, 1);
    check("chain w_idx", w_idx, 0);
    build_ref(blk_b);
    run_stream(1'b0, "chain_b");
`else
    // One IDLE bubble, then B is accepted; W0 shows two cycles after the
    // final handshake of A.
    check("bubble w_valid", w_valid, 0);
    check("bubble in_ready", in_ready, 1);
    check("bubble busy", busy, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    build_ref(blk_b);
    run_stream(1'b0, "held_b");
`endif
    w_ready = 1'b0;

    // Reset mid-stream at w_idx == 20
    load_block(rand_block());
    w_ready = 1'b1;
    n = 0;
    while (w_idx != 6'd20 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reach idx20", w_idx, 20);
    RST = 1'b0;
    #1;
    check("mid rst w_valid", w_valid, 0);
    check("mid rst w_idx", w_idx, 0);
    check("mid rst in_ready", in_ready, 1);
    check("mid rst w_out", w_out, 0);
    check("mid rst busy", busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    w_ready = 1'b0;
    load_block(rand_block());
    run_stream(1'b1, "post_rst");
    w_ready = 1'b0;

    // A few random blocks under random back-pressure
    for (int i = 0; i < 3; i++) begin
      load_block(rand_block());
      run_stream(1'b1, "rand");
      w_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_w_stream.md
# sha256_w_stream

Sequential SHA-256 message-schedule reader. It accepts one 512-bit padded message block, expands it on the fly in a 16-word sliding window, and streams W0..W63 one word per handshake to the round/compression engine. It sits between the block loader and the round core. It is the iterative, consumer-side counterpart of the unrolled schedule pipeline stages.

## Interface
Parameters:
- `ROUNDS`, default 64: words emitted per block; the index width is fixed at 6 bits.

Ports:
- `CLK`: input, 1 bit. Single clock; all state changes on the rising edge.
- `RST`: input, 1 bit. Reset is asynchronous and active-low.
- `in_valid`: input, 1 bit. A block is offered on `block_in`.
- `in_ready`: output, 1 bit. The block is accepted when `in_valid && in_ready` at a clock edge.
- `block_in`: input, 512 bits. W0 at [511:480], W15 at [31:0].
- `w_valid`: output, 1 bit. `w_out` holds a valid schedule word.
- `w_ready`: input, 1 bit. The consumer accepts the word.
- `w_out`: output, 32 bits. Current schedule word W_t.
- `w_idx`: output, 6 bits. t, from 0 to 63.
- `w_last`: output, 1 bit. High when `w_valid` is high and `w_idx` is 63.
- `busy`: output, 1 bit. High in state STREAM.

## Operation
- Window registers: `win[0..15]`, where `win[k]` holds W_{t+k}; `w_out` = `win[0]`.
- FSM states:
  - IDLE: `in_ready`=1, `w_valid`=0.
  - STREAM: `w_valid`=1.
- IDLE -> STREAM on input handshake:
  - `win[k]` <= block word k.
  - Index counter <= 0.
- In STREAM, each output handshake:
  - `win[k]` <= `win[k+1]` for k = 0..14.
  - `win[15]` <= σ1(`win[14]`) + `win[9]` + σ0(`win[1]`) + `win[0]`, computed mod 2^32.
  - Index counter increments.
- Small sigma functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Words computed after t=47 are never emitted; computing them is harmless.
- On the handshake with index 63: STREAM -> IDLE, unless the prefetch feature is enabled (see Configuration).
- No output handshake means no state change; `w_out`, `w_idx` and `w_last` hold steady.
- Reset asserted at any point:
  - All registers clear immediately, and any partial block is discarded.
  - Outputs: `in_ready`=1, `w_valid`=0, `w_out`=0, `w_idx`=0, `w_last`=0, `busy`=0.

## Timing
- Latency: block accepted at edge N gives `w_valid`=1 with W0 in the cycle after edge N.
- Throughput: one word per cycle while `w_ready`=1, so 64 cycles per block.
- Without prefetch: there is one IDLE bubble cycle between blocks.
- `in_ready` is a function of registered state only; there is no combinational path from `w_ready` or `in_valid`.
- `w_valid` never drops without a completed handshake.
- `in_valid` asserted during STREAM (no prefetch): `in_ready`=0, and the block is held upstream.
- Reset released: the module is ready at the first clock edge after deassertion.

## Configuration
- Macro: `SHA256_WSTREAM_PREFETCH_EN`.
- Defined:
  - Adds a 512-bit holding buffer with a full flag.
  - `in_ready` = !full, in any state.
  - An input in STREAM fills the buffer.
  - On the handshake with index 63 and the buffer full: the window loads from the buffer, the buffer is freed, and the index returns to 0. The state stays STREAM with zero bubble.
  - An input in IDLE loads the window directly.
  - Input and output handshakes on the same edge in STREAM are both honoured.
- Undefined: no buffer; `in_ready` is high in IDLE only.

## Structure
- Package `sha256_pkg` holds:
  - `SHA256_WORD_W` (32) and `SHA256_ROUNDS` (64).
  - Functions `sha256_sigma0` and `sha256_sigma1`.
  - The state enum `{IDLE, STREAM}`.
- One sub-module, `sha256_w_next`: combinational next-word computation from `win[0]`, `win[1]`, `win[9]` and `win[14]`. It is shareable with the pipelined schedule stages.

## Test plan
- "abc" padded block:
  - Input: W0=0x61626380, W1..W14=0, W15=0x00000018, `w_ready`=1.
  - Required: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - Required: 64 words with `w_idx` 0..63, and `w_last` only on 63.
- Same block with pseudo-random `w_ready`:
  - Required: the word sequence is identical to the previous test.
  - Required: `w_out` and `w_idx` are stable during every stall.
- All-zero block: 64 words, all 0x00000000, then IDLE with `in_ready`=1.
- `in_valid` held high during STREAM (no prefetch):
  - Required: `in_ready`=0 until the index-63 handshake.
  - Required: the next block's W0 appears 2 cycles after the index-63 handshake.
- Reset asserted mid-stream at `w_idx`=20:
  - Required: `w_valid`=0, `w_idx`=0, `in_ready`=1 immediately.
  - Required: the next block streams from W0.
- With `SHA256_WSTREAM_PREFETCH_EN`, two blocks and `w_ready`=1:
  - Required: 128 consecutive valid cycles.
  - Required: index 63 of block A is followed directly by index 0 of block B.
